uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Transmit-side controller for the UART TX path. It sits directly downstream of the LSB-first parallel-in/serial-out shift register. It drives that register's load and shift-enable strobes, and consumes its serial bit and parity outputs. It generates baud timing and sequences start, data, optional parity and stop bits onto the tx line, with a start/busy/done handshake toward the host.

Parameters:
BAUD_DIV, 5208, clocks per bit period (50 MHz / 9600); legal range >= 2
PARITY_EN, 1, 1 = insert a parity bit after the data bits; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity (bit equals XOR of data); 1 = odd parity (inverted XOR)
STOP_BITS, 1, number of stop bit periods; legal values 1 or 2

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
start  input  1  frame request; sampled only in IDLE; host holds data stable on the shifter input in that cycle
busy  output  1  high while a frame is in progress (START through STOP)
done  output  1  single-cycle pulse when the last stop period ends
piso_load  output  1  load strobe to the shifter
piso_enb  output  1  enable strobe to the shifter
piso_out  input  1  current serial bit from the shifter (bit 0 of its register)
piso_parity  input  1  XOR of the shifter's 8 register bits
tx  output  1  serial line; idle high

Behaviour:
- Reset (rst low, any time, including mid-frame): state=IDLE, baud counter=0, bit counter=0, busy=0, done=0, piso_load=0, piso_enb=0, tx=1 immediately.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Baud counter runs 0..BAUD_DIV-1 and clears on every state entry. tick = (cnt==BAUD_DIV-1). Counter width is $clog2(BAUD_DIV).
- IDLE: tx=1.
  - If start=1 this cycle: piso_load=1 and piso_enb=1 (combinational decode of IDLE & start), and the next state is START.
  - The shifter captures data on the same edge the FSM enters START.
- START: tx=0 for exactly BAUD_DIV clocks. On tick, go to DATA with bit_cnt=0. No shift on this transition.
- DATA: tx=piso_out.
  - On each tick: piso_enb=1 and piso_load=0 for one cycle (one rotate).
  - If bit_cnt<7, increment bit_cnt. Otherwise go to PARITY, or to STOP when PARITY_EN=0.
  - Exactly 8 shifts per frame. The rotation returns the shifter to its loaded value, so piso_parity is unchanged throughout the frame.
- PARITY: tx = piso_parity ^ PARITY_ODD for BAUD_DIV clocks. On tick, go to STOP.
- STOP: tx=1 for STOP_BITS*BAUD_DIV clocks, using a stop counter. On the final tick, go to IDLE and assert done=1 in the first IDLE cycle.
- busy is 1 exactly in the states START, DATA, PARITY and STOP.
- tx is a combinational mux of the registered state and the registered piso_out, so no extra latency is added.
- Latency and frame length:
  - tx falls in the cycle after start is accepted.
  - Frame length = (1 + 8 + PARITY_EN + STOP_BITS) * BAUD_DIV clocks.
  - done occurs exactly one frame length after the accept edge.
- Back-to-back: start=1 in the cycle done=1 is accepted, giving zero idle gap between frames.
- start asserted while busy=1 is ignored: no load, no effect on the current frame.
- piso_load and piso_enb are never high outside the cases above, and both are 0 while rst is low.
- Elaboration asserts: BAUD_DIV>=2 and STOP_BITS in {1,2}.

Decomposition:
- The shared uart_pkg gains:
  - state enum type tx_state_e {IDLE, START, DATA, PARITY, STOP}
  - W_BITCNT = $clog2(W_DATA)
  - default BAUD_DIV constant
- data_t and W_DATA stay in uart_pkg.
- Natural sub-module: uart_baud_cnt (clear input, tick output, parameter BAUD_DIV), reusable by the RX path.
- The controller does not instantiate the shifter. Both are connected by the TX top level.

Test Plan:
- BAUD_DIV=4, even parity, 1 stop, shifter loaded with 0xA5 -> tx per 4-clk period: 0,1,0,1,0,0,1,0,1,0,1; done exactly 44 clks after accept; exactly 8 piso_enb shift pulses.
- PARITY_ODD=1, data 0x07 -> parity bit 0 (even-parity bit would be 1); frame otherwise matches the first case.
- PARITY_EN=0, STOP_BITS=2, data 0x00 -> tx: 0 then eight 0s then 1,1; frame 44 clks; no PARITY state visited.
- Back-to-back 0x55 then 0xAA with start held through done -> second start bit begins the cycle after done; no idle high period between frames.
- Pulse start mid-DATA of 0x3C -> ignored: no piso_load, frame unchanged, single done.
- Assert rst low during DATA bit 3 -> tx=1, busy=0 immediately; after release, a new start with 0xF0 produces a correct full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the TX and RX paths.
package uart_pkg;

    localparam int unsigned W_DATA           = 8;
    localparam int unsigned W_BITCNT         = $clog2(W_DATA);
    localparam int unsigned BAUD_DIV_DEFAULT = 5208;  // 50 MHz / 9600 baud

    typedef logic [W_DATA-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last clock of each period.
module uart_baud_cnt #(
    parameter int unsigned BAUD_DIV = uart_pkg::BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     W_CNT   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(BAUD_DIV - 1);

    logic [W_CNT-1:0] cnt;

    assign tick = (cnt == CNT_MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W_CNT'(1);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: drives the PISO shifter strobes and frames start/data/parity/stop on tx.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic piso_load,
    output logic piso_enb,
    input  logic piso_out,
    input  logic piso_parity,
    output logic tx
);

    localparam logic [W_BITCNT-1:0] BIT_LAST  = W_BITCNT'(W_DATA - 1);
    localparam logic                PAR_INV   = (PARITY_ODD != 0);
    localparam logic                STOP_LAST = (STOP_BITS == 2);

    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_ctrl: BAUD_DIV must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
    end

    tx_state_e           state, state_next;
    logic [W_BITCNT-1:0] bit_cnt, bit_cnt_next;
    logic                stop_cnt, stop_cnt_next;
    logic                done_next;
    logic                tick;
    logic                baud_clear;
    logic                accept;

    // Strobes must stay low while reset is held, even if the host raises start.
    assign accept     = rst && (state == IDLE) && start;
    assign baud_clear = (state == IDLE) || (state_next != state);

    uart_baud_cnt #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            bit_cnt  <= bit_cnt_next;
            stop_cnt <= stop_cnt_next;
            done     <= done_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        done_next     = 1'b0;
        piso_load     = 1'b0;
        piso_enb      = 1'b0;
        tx            = 1'b1;
        busy          = 1'b1;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    piso_load  = 1'b1;
                    piso_enb   = 1'b1;
                    state_next = START;
                end
            end

            START: begin
                tx = 1'b0;
                if (tick) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end

            DATA: begin
                tx = piso_out;
                if (tick) begin
                    // Eight rotates bring the shifter back to its loaded value.
                    piso_enb = 1'b1;
                    if (bit_cnt < BIT_LAST) begin
                        bit_cnt_next = bit_cnt + W_BITCNT'(1);
                    end else if (PARITY_EN != 0) begin
                        state_next = PARITY;
                    end else begin
                        state_next    = STOP;
                        stop_cnt_next = 1'b0;
                    end
                end
            end

            PARITY: begin
                tx = piso_parity ^ PAR_INV;
                if (tick) begin
                    state_next    = STOP;
                    stop_cnt_next = 1'b0;
                end
            end

            STOP: begin
                if (tick) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        stop_cnt_next = 1'b1;
                    end
                end
            end

            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: three parameter sets, behavioural shifter, bit-level scoreboard.
module tb_uart_tx_ctrl;

    localparam int BD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      start, busy, done, load, enb, tx;
    logic [2:0][7:0] din, sh;

    int enb_cnt  [3] = '{0, 0, 0};
    int load_cnt [3] = '{0, 0, 0};
    int done_cnt [3] = '{0, 0, 0};

    int   n_vec = 0;
    int   n_err = 0;
    logic exp_q [$];
    int   base_enb, base_load, base_done;

    always #5 clk = ~clk;

    // Instance 0: even parity, 1 stop. Instance 1: odd parity. Instance 2: no parity, 2 stops.
    uart_tx_ctrl #(.BAUD_DIV(BD), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_even (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .piso_load(load[0]), .piso_enb(enb[0]), .piso_out(sh[0][0]),
        .piso_parity(^sh[0]), .tx(tx[0]));

    uart_tx_ctrl #(.BAUD_DIV(BD), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_odd (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .piso_load(load[1]), .piso_enb(enb[1]), .piso_out(sh[1][0]),
        .piso_parity(^sh[1]), .tx(tx[1]));

    uart_tx_ctrl #(.BAUD_DIV(BD), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_nopar (
        .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .piso_load(load[2]), .piso_enb(enb[2]), .piso_out(sh[2][0]),
        .piso_parity(^sh[2]), .tx(tx[2]));

    // Behavioural LSB-first rotating shifter plus strobe counters.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (load[k]) begin
                sh[k]       <= din[k];
                load_cnt[k] <= load_cnt[k] + 1;
            end else if (enb[k]) begin
                sh[k]      <= {sh[k][0], sh[k][7:1]};
                enb_cnt[k] <= enb_cnt[k] + 1;
            end
            if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
        end
    end

    function automatic int cfg_pen(input int k);
        return (k == 2) ? 0 : 1;
    endfunction

    function automatic logic cfg_odd(input int k);
        return (k == 1);
    endfunction

    function automatic int cfg_stops(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int k, input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (cfg_pen(k) != 0) exp_q.push_back((^d) ^ cfg_odd(k));
        for (int s = 0; s < cfg_stops(k); s++) exp_q.push_back(1'b1);
    endtask

    // Called at a negedge with DUT k idle; returns at the negedge of the first START cycle.
    task automatic begin_frame(input int k, input logic [7:0] d);
        din[k]    = d;
        start[k]  = 1'b1;
        base_enb  = enb_cnt[k];
        base_load = load_cnt[k];
        base_done = done_cnt[k];
        push_frame(k, d);
        @(negedge clk);
        check("tx_fall_after_accept", tx[k], 1'b0);
        check("busy_after_accept", busy[k], 1'b1);
    endtask

    // Walks the whole frame, comparing tx mid-period; ends at the negedge of the done cycle.
    task automatic watch_frame(input int k, input logic keep_start, input int pulse_at);
        int   len;
        logic e;
        len = (1 + 8 + cfg_pen(k) + cfg_stops(k)) * BD;
        start[k] = keep_start;
        for (int c = 0; c < len; c++) begin
            if (c == pulse_at) start[k] = 1'b1;
            else if (c == pulse_at + 1) start[k] = keep_start;
            if (c % BD == BD / 2) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("tx_dut%0d_bit%0d", k, c / BD), tx[k], e);
                end
            end
            if (c == len - 1) check("done_low_before_end", done[k], 1'b0);
            @(negedge clk);
        end
        check("done_at_frame_end", done[k], 1'b1);
        check("busy_low_at_done", busy[k], 1'b0);
        check("shift_pulses", enb_cnt[k] - base_enb, 8);
        check("load_pulses", load_cnt[k] - base_load, 1);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        rst   = 1'b0;
        start = '0;
        din   = '0;
        start[0] = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_tx", tx[k], 1'b1);
            check("rst_busy", busy[k], 1'b0);
            check("rst_done", done[k], 1'b0);
            check("rst_strobes", {load[k], enb[k]}, 2'b00);
        end
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Even parity, 0xA5
        begin_frame(0, 8'hA5);
        watch_frame(0, 1'b0, -1);
        check("done_count_a5", done_cnt[0] - base_done, 0);
        @(negedge clk);
        check("done_single_cycle", done[0], 1'b0);
        check("done_count_a5_after", done_cnt[0] - base_done, 1);

        // Odd parity, 0x07: parity bit 0
        begin_frame(1, 8'h07);
        watch_frame(1, 1'b0, -1);
        @(negedge clk);

        // No parity, two stop bits, 0x00
        begin_frame(2, 8'h00);
        watch_frame(2, 1'b0, -1);
        @(negedge clk);

        // Back-to-back 0x55 then 0xAA, start held high throughout
        begin_frame(0, 8'h55);
        watch_frame(0, 1'b1, -1);
        begin_frame(0, 8'hAA);
        watch_frame(0, 1'b0, -1);
        @(negedge clk);

        // start pulsed mid-DATA is ignored
        begin_frame(0, 8'h3C);
        watch_frame(0, 1'b0, 18);
        @(negedge clk);
        check("single_done_3c", done_cnt[0] - base_done, 1);
        check("idle_after_3c", busy[0], 1'b0);

        // Reset during DATA bit 3, then a clean 0xF0 frame
        begin_frame(0, 8'h96);
        for (int c = 0; c < 17; c++) @(negedge clk);
        check("busy_before_rst", busy[0], 1'b1);
        rst = 1'b0;
        start[0] = 1'b1;
        #1;
        check("midrst_tx", tx[0], 1'b1);
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_strobes", {load[0], enb[0]}, 2'b00);
        exp_q.delete();
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_after_rst_release", {busy[0], tx[0]}, 2'b01);
        begin_frame(0, 8'hF0);
        watch_frame(0, 1'b0, -1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
